// File: rtl/std_rrarb_reg.sv
// std_rrarb_reg: round-robin arbiter feeding a single registered valid/ready output slot
module std_rrarb_reg #(
  parameter int REQ_COUNT = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REQ_COUNT-1:0]            req_valid,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0] req_data,
  output logic [REQ_COUNT-1:0]            req_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [IDX_WIDTH-1:0]            out_src,
  input  logic                            out_ready
);
  logic [IDX_WIDTH-1:0]  rr_ptr;
  logic [IDX_WIDTH-1:0]  winner;
  logic [IDX_WIDTH-1:0]  nxt_ptr;
  logic                  found;
  logic                  can_load;
  logic                  load;
  logic [DATA_WIDTH-1:0] data_arr [REQ_COUNT];

  for (genvar g = 0; g < REQ_COUNT; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // scan from the priority pointer, wrapping modulo REQ_COUNT, and take the first valid requester
  always_comb begin
    logic [IDX_WIDTH:0] s;
    found = 1'b0;
    winner = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      s = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(k);
      s = (s >= (IDX_WIDTH+1)'(REQ_COUNT)) ? s - (IDX_WIDTH+1)'(REQ_COUNT) : s;
      if (!found && req_valid[s[IDX_WIDTH-1:0]]) begin
        found = 1'b1;
        winner = s[IDX_WIDTH-1:0];
      end
    end
  end

  assign can_load  = ~out_valid | out_ready;
  assign load      = found & can_load & ~reset;
  assign req_ready = load ? (REQ_COUNT'(1) << winner) : '0;
  assign nxt_ptr   = (winner == IDX_WIDTH'(REQ_COUNT-1)) ? '0 : winner + 1'b1;

  // output slot: load the winner (replacing any draining entry), otherwise empty on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[winner];
      out_src   <= winner;
      rr_ptr    <= nxt_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_std_rrarb_reg.sv
// tb_std_rrarb_reg: directed scoreboard bench for the round-robin output-slot arbiter
module tb_std_rrarb_reg;
  typedef struct {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = 4'b1111;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_ready = 1'b1;

  logic [2:0]   v3 = '0;
  logic [95:0]  d3 = '0;
  logic [2:0]   r3;
  logic         ov3;
  logic [31:0]  od3;
  logic [1:0]   os3;

  int           compared = 0;
  int           mismatched = 0;
  logic [31:0]  base = 32'h1000_0000;
  exp_t         sbq[$];
  exp_t         last;

  always #5 clk = ~clk;

  std_rrarb_reg #(.REQ_COUNT(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  std_rrarb_reg #(.REQ_COUNT(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_data(d3),
    .req_ready(r3), .out_valid(ov3), .out_data(od3),
    .out_src(os3), .out_ready(1'b1)
  );

  function automatic logic [31:0] data_of(input int i);
    return base ^ (32'h0101_0101 * 32'(i + 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = data_of(i);
    for (int i = 0; i < 3; i++) d3[i*32 +: 32] = data_of(i) ^ 32'hFFFF_0000;
  endtask

  task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy, input logic exp_ov);
    exp_t e;
    req_valid = v;
    out_ready = ordy;
    drive_data();
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) e.src = 2'(i);
      e.data = data_of(int'(e.src));
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov && sbq.size() != 0) last = sbq.pop_front();
    if (exp_ov) begin
      check("out_src", 32'(out_src), 32'(last.src));
      check("out_data", out_data, last.data);
    end
  endtask

  task automatic step3(input logic [2:0] v, input logic [2:0] exp_rdy, input logic [1:0] exp_src);
    v3 = v;
    drive_data();
    #1;
    check("r3_ready", 32'(r3), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check("r3_out_valid", 32'(ov3), 32'd1);
    check("r3_out_src", 32'(os3), 32'(exp_src));
    check("r3_out_data", od3, data_of(int'(exp_src)) ^ 32'hFFFF_0000);
  endtask

  initial begin
    drive_data();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_r3_ready", 32'(r3), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_src", 32'(out_src), 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      base = 32'h2000_0000 + 32'(k << 8);
      step(4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b1);
    end
    base = 32'h3000_0000;
    step(4'b0110, 1'b1, 4'b0010, 1'b1);
    step(4'b0110, 1'b1, 4'b0100, 1'b1);
    step(4'b0110, 1'b1, 4'b0010, 1'b1);
    base = 32'h4000_0000;
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b0, 4'b0000, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    base = 32'h5000_0000;
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0010, 1'b1, 4'b0010, 1'b1);
    reset = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_src", 32'(out_src), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    reset = 1'b0;
    base = 32'h6000_0000;
    step(4'b1111, 1'b1, 4'b0001, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    base = 32'h7000_0000;
    step3(3'b111, 3'b001, 2'd0);
    step3(3'b111, 3'b010, 2'd1);
    step3(3'b111, 3'b100, 2'd2);
    step3(3'b111, 3'b001, 2'd0);
    step3(3'b101, 3'b100, 2'd2);
    step3(3'b101, 3'b001, 2'd0);
    step3(3'b011, 3'b010, 2'd1);
    check("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/std_rrarb_reg.md
Name: std_rrarb_reg

Overview:
- Round-robin arbiter that shares one registered output slot, built on synchronous-reset DFF storage, between REQ_COUNT requesters.
- Each requester presents a valid/ready channel. The block picks one winner per cycle, loads its data into the output register and presents it downstream on a valid/ready channel.
- Used wherever several pipeline sources feed a single consumer, e.g. a shared memory or CSR port.

Parameters:
- REQ_COUNT, 4, number of requesters; legal range 1..16.
- DATA_WIDTH, 32, width of each requester's payload.
- IDX_WIDTH, derived (not user-set), max(1, clog2(REQ_COUNT)); width of source index.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  REQ_COUNT  per-requester valid; bit i belongs to requester i.
- req_data  input  REQ_COUNT*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  REQ_COUNT  one-hot (or zero) grant/accept; a transfer occurs when req_valid[i] & req_ready[i].
- out_valid  output  1  output slot holds valid data.
- out_data  output  DATA_WIDTH  registered payload.
- out_src  output  IDX_WIDTH  index of the requester whose payload is in the slot.
- out_ready  input  1  downstream accept; drain occurs when out_valid & out_ready.

Behaviour:
- Reset (sync, while reset=1 at posedge): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - req_ready is combinational and therefore 0 while out_valid=0 is not sufficient to force it low. It must be forced to 0 whenever reset=1.
  - Reset mid-transfer discards the slot contents. No transfer is counted in a cycle where reset=1.
- Internal state: out_valid, out_data, out_src, and rr_ptr (IDX_WIDTH bits, range 0..REQ_COUNT-1). The priority pointer holds the highest-priority index.
- can_load = ~out_valid | out_ready (slot empty or being drained this cycle).
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo REQ_COUNT (not modulo 2^IDX_WIDTH).
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = can_load; all other req_ready bits = 0. No winner means req_ready = 0.
  - req_ready never depends on out_ready except through can_load. No combinational path exists from req_valid to out_valid.
- Load (posedge, transfer occurred):
  - out_data <= req_data[winner]; out_src <= winner; out_valid <= 1.
  - rr_ptr <= (winner+1) mod REQ_COUNT, wrapping from REQ_COUNT-1 to 0.
- Drain without load: out_valid <= 0. out_data and out_src hold their stale values; they are don't-care while out_valid=0 but are not cleared.
- Simultaneous drain and load: the slot is replaced in the same cycle, giving full throughput of 1 transfer/cycle.
- Stall (out_valid=1, out_ready=0): out_valid, out_data and out_src stay stable, req_ready=0 and rr_ptr holds.
- Latency: 1 cycle from accepted request to out_valid.
- Fairness: a continuously asserting requester waits at most REQ_COUNT-1 transfers before it is granted.
- Requester rule: once req_valid is asserted it must hold valid and data until accepted. The arbiter does not require grant stability across cycles in which no transfer occurs.
- REQ_COUNT=1: rr_ptr stays 0, out_src=0, and the block degenerates to a registered one-entry buffer.

Test Plan:
- Reset: hold reset for 3 cycles with all req_valid=1 and out_ready=1 -> req_ready=0, out_valid=0, out_data=0, out_src=0 throughout. The first post-reset grant goes to requester 0.
- Rotation: REQ_COUNT=4, all valid, out_ready=1 for 8 cycles -> out_src sequence is 0,1,2,3,0,1,2,3, out_valid stays 1 continuously, and each out_data matches its source.
- Sparse and wrap: after granting index 3, only req_valid[1] and [2] are set -> grant 1, then 2, then 1. Confirms wrap modulo REQ_COUNT with non-power-of-2 REQ_COUNT=3 (sequence 2,0,1).
- Backpressure: slot full with out_ready=0 for 5 cycles while req_valid=1111 -> req_ready=0 and out_data/out_src are unchanged. When out_ready rises, the next winner loads in the same cycle with no bubble.
- Single requester / empty: only req_valid[2] pulses for 1 cycle -> out_valid the next cycle with out_src=2. With out_ready=1 and no further requests, out_valid drops to 0 the cycle after.
- Reset mid-operation: assert reset while out_valid=1 and rr_ptr=2 -> next cycle out_valid=0 and rr_ptr=0, and a subsequent all-valid request grants 0 first.
